// File: rtl/image_conv_quan_fifo_feed_pkg.sv
// Shared defaults and types for the conv-to-quantization row FIFO write side.
// Holds default beat/address widths, the Wait-state length and the FSM encoding.
package image_conv_quan_fifo_feed_pkg;

  localparam int unsigned QF_DATA_WIDTH = 256;
  localparam int unsigned QF_ADDR_WIDTH = 12;
  localparam int unsigned WAIT_CYCLES   = 4;
  localparam int unsigned ROW_W         = 11;
  localparam int unsigned BEAT_W        = 14;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RUN
  } state_e;

endpackage

// File: rtl/image_conv_quan_fifo_feed_ram.sv
// Simple dual-port RAM backing the row FIFO: one write port, one registered read port.
// Read data holds its last value whenever no read is issued.
module image_quan_fifo_ram #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // NOTE: the storage array has no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)          o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/image_conv_quan_fifo_feed.sv
// Write side of the conv-to-quantization row FIFO; raises fifo_valid once a full row is buffered.
// Optional protocol checking is enabled by defining QUAN_FIFO_ERR_CHECK_EN.
module image_conv_quan_fifo_feed
  import image_conv_quan_fifo_feed_pkg::*;
#(
  parameter int DATA_WIDTH = QF_DATA_WIDTH,
  parameter int ADDR_WIDTH = QF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [ROW_W-1:0]      Row_Num_Out_REG,
  input  logic [BEAT_W-1:0]     S_Count_Fifo,
  input  logic [DATA_WIDTH-1:0] S_Data,
  input  logic                  S_Valid,
  output logic                  S_Ready,
  input  logic                  rd_en_fifo,
  output logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_valid,
  output logic                  Done,
  output logic                  err_flag
);

  localparam int WAIT_W = $clog2(WAIT_CYCLES);
  localparam int CMP_W  = (ADDR_WIDTH + 1 > BEAT_W) ? ADDR_WIDTH + 1 : BEAT_W;
  localparam logic [ADDR_WIDTH:0]   OCC_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);

  state_e                r_state, w_state_nxt;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [BEAT_W-1:0]     r_row_len;
  logic [ROW_W-1:0]      r_rows_total;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_occ;
  logic [BEAT_W-1:0]     r_wr_beat, r_rd_beat;
  logic [ROW_W-1:0]      r_wr_rows, r_rd_rows;

  logic                  w_run, w_wait_done, w_wr, w_rd_req, w_rd, w_empty, w_last_read;
  logic [BEAT_W-1:0]     w_beat_last;
  logic [ROW_W-1:0]      w_row_last;

  assign w_run       = (r_state == S_RUN);
  assign w_wait_done = (r_state == S_WAIT) && (r_wait_cnt == WAIT_LAST);
  assign w_empty     = (r_occ == '0);
  assign w_beat_last = r_row_len - BEAT_W'(1);
  assign w_row_last  = r_rows_total - ROW_W'(1);

  assign S_Ready     = w_run && (r_occ < OCC_FULL) && (r_wr_rows < r_rows_total);
  assign fifo_valid  = w_run && (CMP_W'(r_occ) >= CMP_W'(r_row_len));

  assign w_wr        = S_Valid && S_Ready;
  assign w_rd_req    = w_run && rd_en_fifo;
  assign w_rd        = w_rd_req && !w_empty;
  assign w_last_read = w_rd && (r_rd_beat == w_beat_last) && (r_rd_rows == w_row_last);

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (Start)       w_state_nxt = S_WAIT;
      S_WAIT:  if (w_wait_done) w_state_nxt = S_RUN;
      S_RUN:   if (w_last_read) w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every sequential block uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || r_state != S_WAIT) r_wait_cnt <= '0;
    else                          r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
  end

  // Layer geometry is captured once S_Count_Fifo has settled from the controller multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_len    <= '0;
      r_rows_total <= '0;
    end else if (w_wait_done) begin
      r_row_len    <= S_Count_Fifo;
      r_rows_total <= Row_Num_Out_REG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !w_run) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      r_wr_beat <= '0;
      r_rd_beat <= '0;
      r_wr_rows <= '0;
      r_rd_rows <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
        if (r_wr_beat == w_beat_last) begin
          r_wr_beat <= '0;
          r_wr_rows <= r_wr_rows + ROW_W'(1);
        end else begin
          r_wr_beat <= r_wr_beat + BEAT_W'(1);
        end
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
        if (r_rd_beat == w_beat_last) begin
          r_rd_beat <= '0;
          r_rd_rows <= r_rd_rows + ROW_W'(1);
        end else begin
          r_rd_beat <= r_rd_beat + BEAT_W'(1);
        end
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_occ <= r_occ + (ADDR_WIDTH + 1)'(1);
        2'b01:   r_occ <= r_occ - (ADDR_WIDTH + 1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) Done <= 1'b0;
    else     Done <= w_last_read;
  end

`ifdef QUAN_FIFO_ERR_CHECK_EN
  logic r_err;
  logic w_err_evt;

  // A read into an empty FIFO, or a row started before a full row was buffered.
  assign w_err_evt = w_rd_req && (w_empty || (r_rd_beat == '0 && !fifo_valid));

  always_ff @(posedge clk) begin
    if (rst || Start)   r_err <= 1'b0;
    else if (w_err_evt) r_err <= 1'b1;
  end

  assign err_flag = r_err;
`else
  assign err_flag = 1'b0;
`endif

  image_quan_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (S_Data),
    .i_rd_en   (w_rd),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (fifo_dout)
  );

endmodule

// File: tb/tb_image_conv_quan_fifo_feed.sv
// Directed self-checking bench for image_conv_quan_fifo_feed (32-bit beats, 32-deep FIFO).
// Expected err_flag follows QUAN_FIFO_ERR_CHECK_EN when the bench is built with it.
module tb_image_conv_quan_fifo_feed;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef QUAN_FIFO_ERR_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          Start = 1'b0;
  logic [10:0]   Row_Num_Out_REG = '0;
  logic [13:0]   S_Count_Fifo = '0;
  logic [DW-1:0] S_Data = '0;
  logic          S_Valid = 1'b0;
  logic          S_Ready;
  logic          rd_en_fifo = 1'b0;
  logic [DW-1:0] fifo_dout;
  logic          fifo_valid;
  logic          Done;
  logic          err_flag;

  int n_tests = 0;
  int n_fail  = 0;
  int acc;

  always #5 clk = ~clk;

  image_conv_quan_fifo_feed #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .Start           (Start),
    .Row_Num_Out_REG (Row_Num_Out_REG),
    .S_Count_Fifo    (S_Count_Fifo),
    .S_Data          (S_Data),
    .S_Valid         (S_Valid),
    .S_Ready         (S_Ready),
    .rd_en_fifo      (rd_en_fifo),
    .fifo_dout       (fifo_dout),
    .fifo_valid      (fifo_valid),
    .Done            (Done),
    .err_flag        (err_flag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start pulse, then confirm S_Ready stays low through the 4-cycle wait.
  task automatic do_start(input logic [10:0] rows, input logic [13:0] len);
    Row_Num_Out_REG = rows;
    S_Count_Fifo    = len;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    check("ready_in_wait", 32'(S_Ready), 32'd0);
    tick();
    check("ready_in_run", 32'(S_Ready), 32'd1);
  endtask

  task automatic write_beats(input int count, input logic [31:0] base, input int budget,
                             output int accepted);
    accepted = 0;
    S_Valid  = 1'b1;
    for (int cyc = 0; cyc < budget && accepted < count; cyc++) begin
      S_Data = base + 32'(accepted);
      if (S_Ready) begin
        tick();
        accepted++;
      end else begin
        tick();
      end
    end
    S_Valid = 1'b0;
  endtask

  task automatic read_beats(input int count, input logic [31:0] base);
    for (int i = 0; i < count; i++) begin
      rd_en_fifo = 1'b1;
      tick();
      check("rd_data", fifo_dout, base + 32'(i));
    end
    rd_en_fifo = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    check("rst_ready", 32'(S_Ready), 32'd0);
    check("rst_valid", 32'(fifo_valid), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_dout", fifo_dout, 32'd0);
    check("rst_err", 32'(err_flag), 32'd0);

    // Layer A: 4 rows of 8 beats, full write then row-burst reads.
    do_start(11'd4, 14'd8);
    write_beats(7, 32'hA000_0000, 20, acc);
    check("a_acc7", 32'(acc), 32'd7);
    check("a_valid_7", 32'(fifo_valid), 32'd0);
    write_beats(1, 32'hA000_0007, 5, acc);
    check("a_valid_8", 32'(fifo_valid), 32'd1);
    write_beats(24, 32'hA000_0008, 40, acc);
    check("a_acc24", 32'(acc), 32'd24);
    check("a_ready_end", 32'(S_Ready), 32'd0);
    for (int r = 0; r < 3; r++) begin
      check("a_valid_row", 32'(fifo_valid), 32'd1);
      read_beats(8, 32'hA000_0000 + 32'(r * 8));
    end
    check("a_done_early", 32'(Done), 32'd0);
    read_beats(1, 32'hA000_0018);
    check("a_valid_partial", 32'(fifo_valid), 32'd0);
    read_beats(7, 32'hA000_0019);
    check("a_done", 32'(Done), 32'd1);
    tick();
    check("a_done_pulse", 32'(Done), 32'd0);
    check("a_idle_ready", 32'(S_Ready), 32'd0);

    // Layer B: steady simultaneous read/write, fill to full, then mid-layer reset.
    do_start(11'd8, 14'd8);
    write_beats(8, 32'hB000_0000, 20, acc);
    check("b_valid", 32'(fifo_valid), 32'd1);
    for (int k = 0; k < 20; k++) begin
      S_Valid    = 1'b1;
      S_Data     = 32'hB000_0008 + 32'(k);
      rd_en_fifo = 1'b1;
      check("b_rw_ready", 32'(S_Ready), 32'd1);
      tick();
      check("b_rw_data", fifo_dout, 32'hB000_0000 + 32'(k));
      check("b_rw_valid", 32'(fifo_valid), 32'd1);
    end
    S_Valid    = 1'b0;
    rd_en_fifo = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("b_start_ignored", 32'(S_Ready), 32'd1);
    check("b_valid_hold", 32'(fifo_valid), 32'd1);
    write_beats(40, 32'hB000_001C, 60, acc);
    check("b_fill_acc", 32'(acc), 32'd24);
    check("b_full_ready", 32'(S_Ready), 32'd0);
    rd_en_fifo = 1'b1;
    S_Valid    = 1'b1;
    S_Data     = 32'hB000_0034;
    tick();
    rd_en_fifo = 1'b0;
    check("b_full_rd_data", fifo_dout, 32'hB000_0014);
    check("b_ready_after_rd", 32'(S_Ready), 32'd1);
    tick();
    S_Valid = 1'b0;
    check("b_refull_ready", 32'(S_Ready), 32'd0);
    rst = 1'b1;
    tick();
    check("b_rst_ready", 32'(S_Ready), 32'd0);
    check("b_rst_valid", 32'(fifo_valid), 32'd0);
    check("b_rst_dout", fifo_dout, 32'd0);
    check("b_rst_done", 32'(Done), 32'd0);
    rst = 1'b0;

    // Layer C: read while empty, then a clean one-row layer.
    do_start(11'd1, 14'd4);
    rd_en_fifo = 1'b1;
    tick();
    rd_en_fifo = 1'b0;
    check("c_err_set", 32'(err_flag), 32'(ERR_EXP));
    check("c_dout_hold", fifo_dout, 32'd0);
    tick();
    check("c_err_held", 32'(err_flag), 32'(ERR_EXP));
    check("c_valid_empty", 32'(fifo_valid), 32'd0);
    write_beats(4, 32'hC000_0000, 10, acc);
    check("c_valid", 32'(fifo_valid), 32'd1);
    read_beats(4, 32'hC000_0000);
    check("c_done", 32'(Done), 32'd1);
    check("c_err_final", 32'(err_flag), 32'(ERR_EXP));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
